// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Port ids index the request vector: bit PROC is the processor, bit LOADER the loader.
package mem_arb_pkg;

    localparam int unsigned DATA_W_DEF   = 16;
    localparam int unsigned ADDR_W_DEF   = 5;
    localparam int unsigned LOCK_MAX_DEF = 4;

    localparam logic PROC   = 1'b0;
    localparam logic LOADER = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        GRANT_C,
        GRANT_L,
        READ_C,
        READ_L
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational two-way round-robin picker; force_proc_i overrides a tie in favour
// of the processor.
module rr_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_winner_i,
    input  logic       force_proc_i,
    output logic       winner_o,
    output logic       valid_o
);

    always_comb begin
        valid_o  = |req_i;
        winner_o = PROC;
        case (req_i)
            2'b01:   winner_o = PROC;
            2'b10:   winner_o = LOADER;
            2'b11:   winner_o = force_proc_i ? PROC : ~last_winner_i;
            default: winner_o = PROC;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port memory between processor (c_) and loader (l_).
// Optional processor bus lock is enabled with `define MEM_ARB_LOCK_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF
`ifdef MEM_ARB_LOCK_EN
    ,
    parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              c_req_i,
    input  logic              c_we_i,
    input  logic [ADDR_W-1:0] c_addr_i,
    input  logic [DATA_W-1:0] c_wdata_i,
    output logic              c_gnt_o,
    output logic              c_rvalid_o,
    output logic [DATA_W-1:0] c_rdata_o,
    input  logic              l_req_i,
    input  logic              l_we_i,
    input  logic [ADDR_W-1:0] l_addr_i,
    input  logic [DATA_W-1:0] l_wdata_i,
    output logic              l_gnt_o,
    output logic              l_rvalid_o,
    output logic [DATA_W-1:0] l_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
`ifdef MEM_ARB_LOCK_EN
    ,
    input  logic              c_lock_i
`endif
);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              winner;
    logic              pick_valid;
    logic              force_proc;

`ifdef MEM_ARB_LOCK_EN
    localparam int unsigned LockW = $clog2(LOCK_MAX + 1);

    logic [LockW-1:0] lock_cnt_q, lock_cnt_d;

    assign force_proc = c_req_i && l_req_i && (last_q == PROC) && c_lock_i &&
                        (lock_cnt_q < LockW'(LOCK_MAX));
`else
    assign force_proc = 1'b0;
`endif

    rr_pick u_rr_pick (
        .req_i         ({l_req_i, c_req_i}),
        .last_winner_i (last_q),
        .force_proc_i  (force_proc),
        .winner_o      (winner),
        .valid_o       (pick_valid)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            last_q     <= LOADER;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
`ifdef MEM_ARB_LOCK_EN
            lock_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
`ifdef MEM_ARB_LOCK_EN
            lock_cnt_q <= lock_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
`ifdef MEM_ARB_LOCK_EN
        lock_cnt_d  = lock_cnt_q;
`endif
        c_gnt_o     = 1'b0;
        l_gnt_o     = 1'b0;
        c_rvalid_o  = 1'b0;
        l_rvalid_o  = 1'b0;
        c_rdata_o   = '0;
        l_rdata_o   = '0;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        busy_o      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    last_d = winner;
                    if (winner == PROC) begin
                        we_d    = c_we_i;
                        addr_d  = c_addr_i;
                        wdata_d = c_wdata_i;
                        state_d = GRANT_C;
                    end else begin
                        we_d    = l_we_i;
                        addr_d  = l_addr_i;
                        wdata_d = l_wdata_i;
                        state_d = GRANT_L;
                    end
                end
`ifdef MEM_ARB_LOCK_EN
                if (!c_lock_i || (pick_valid && winner == LOADER)) begin
                    lock_cnt_d = '0;
                end else if (force_proc) begin
                    lock_cnt_d = lock_cnt_q + LockW'(1);
                end
`endif
            end
            GRANT_C, GRANT_L: begin
                c_gnt_o     = (state_q == GRANT_C);
                l_gnt_o     = (state_q == GRANT_L);
                mem_addr_o  = addr_q;
                mem_we_o    = we_q;
                mem_wdata_o = wdata_q;
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = (state_q == GRANT_C) ? READ_C : READ_L;
                end
            end
            READ_C: begin
                c_rvalid_o = 1'b1;
                c_rdata_o  = mem_rdata_i;
                state_d    = IDLE;
            end
            READ_L: begin
                l_rvalid_o = 1'b1;
                l_rdata_o  = mem_rdata_i;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous memory.
// Lock scenario compiled only with MEM_ARB_LOCK_EN.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we, l_req, l_we, c_lock;
    logic [4:0]  c_addr, l_addr, mem_addr;
    logic [15:0] c_wdata, l_wdata, c_rdata, l_rdata, mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic        c_gnt, l_gnt, c_rvalid, l_rvalid, mem_we, busy;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [32];
    logic [31:0] written = '0;

    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(input logic [4:0] a);
        case (a)
            5'd1:    return 16'hC001;
            5'd2:    return 16'hA002;
            5'd3:    return 16'h1234;
            default: return 16'h0000;
        endcase
    endfunction

    // Memory registers read data one edge after the address, write lands on the same edge
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        mem_rdata <= written[mem_addr] ? mem[mem_addr] : init_word(mem_addr);
    end

    mem_port_arbiter dut (
        .clk_i       (clk),
        .rst_i       (reset),
        .c_req_i     (c_req),
        .c_we_i      (c_we),
        .c_addr_i    (c_addr),
        .c_wdata_i   (c_wdata),
        .c_gnt_o     (c_gnt),
        .c_rvalid_o  (c_rvalid),
        .c_rdata_o   (c_rdata),
        .l_req_i     (l_req),
        .l_we_i      (l_we),
        .l_addr_i    (l_addr),
        .l_wdata_i   (l_wdata),
        .l_gnt_o     (l_gnt),
        .l_rvalid_o  (l_rvalid),
        .l_rdata_o   (l_rdata),
        .mem_addr_o  (mem_addr),
        .mem_we_o    (mem_we),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .busy_o      (busy)
`ifdef MEM_ARB_LOCK_EN
        ,
        .c_lock_i    (c_lock)
`endif
    );

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({c_gnt, l_gnt, c_rvalid, l_rvalid, mem_we, busy} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {c_gnt, l_gnt, c_rvalid, l_rvalid, mem_we, busy});
        end
        total++;
        if ({c_rdata, l_rdata, mem_wdata, mem_addr} !== 53'h0) begin
            bad++;
            $display("FAIL reset_data: got %h expected 0", {c_rdata, l_rdata, mem_wdata, mem_addr});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        l_req = 1'b1; l_we = 1'b0; l_addr = 5'd3;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL rd_idle_busy: got %b expected 0", busy); end
        @(negedge clk);
        total++;
        if ({l_gnt, c_gnt, busy, mem_we} !== 4'b1010) begin
            bad++;
            $display("FAIL rd_grant: got %b expected 1010", {l_gnt, c_gnt, busy, mem_we});
        end
        total++;
        if (mem_addr !== 5'd3) begin bad++; $display("FAIL rd_addr: got %0d expected 3", mem_addr); end
        l_req = 1'b0;
        @(negedge clk);
        total++;
        if ({l_rvalid, c_rvalid, busy, l_gnt} !== 4'b1010) begin
            bad++;
            $display("FAIL rd_valid: got %b expected 1010", {l_rvalid, c_rvalid, busy, l_gnt});
        end
        total++;
        if (l_rdata !== 16'h1234) begin bad++; $display("FAIL rd_data: got %h expected 1234", l_rdata); end
        @(negedge clk);
        total++;
        if ({busy, l_rvalid, l_rdata} !== 18'h0) begin
            bad++;
            $display("FAIL rd_done: got %h expected 0", {busy, l_rvalid, l_rdata});
        end
    endtask

    task automatic test_write_readback();
        c_req = 1'b1; c_we = 1'b1; c_addr = 5'd7; c_wdata = 16'hBEEF;
        @(negedge clk);
        total++;
        if ({c_gnt, mem_we, busy, l_gnt} !== 4'b1110) begin
            bad++;
            $display("FAIL wr_grant: got %b expected 1110", {c_gnt, mem_we, busy, l_gnt});
        end
        total++;
        if ({mem_addr, mem_wdata} !== {5'd7, 16'hBEEF}) begin
            bad++;
            $display("FAIL wr_bus: got %h expected 7beef", {mem_addr, mem_wdata});
        end
        c_req = 1'b0;
        @(negedge clk);
        total++;
        if ({mem_we, busy, c_gnt, mem_addr} !== 8'h0) begin
            bad++;
            $display("FAIL wr_one_cycle: got %h expected 0", {mem_we, busy, c_gnt, mem_addr});
        end
        c_req = 1'b1; c_we = 1'b0;
        @(negedge clk);
        total++;
        if ({c_gnt, mem_we} !== 2'b10) begin
            bad++;
            $display("FAIL rb_grant: got %b expected 10", {c_gnt, mem_we});
        end
        c_req = 1'b0;
        @(negedge clk);
        total++;
        if ({c_rvalid, l_rvalid, c_rdata} !== {2'b10, 16'hBEEF}) begin
            bad++;
            $display("FAIL rb_data: got %h expected 2beef", {c_rvalid, l_rvalid, c_rdata});
        end
        @(negedge clk);
    endtask

    // Collects grants with both ports requesting reads; pend tracks which port owes rvalid.
    task automatic run_tie(input int n, input logic [7:0] exp_order, input string tag);
        int          ngr = 0;
        int          pend = -1;
        logic [7:0]  order = '0;
        reset = 1'b1;
        c_req = 1'b1; c_we = 1'b0; c_addr = 5'd1;
        l_req = 1'b1; l_we = 1'b0; l_addr = 5'd2;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 80 && !(ngr == n && pend == -1); i++) begin
            @(negedge clk);
            if (c_gnt && l_gnt) begin
                total++; bad++;
                $display("FAIL %s_both_gnt: got 11 expected at most one", tag);
            end
            if (pend == 0) begin
                total++;
                if ({c_rvalid, l_rvalid, c_rdata} !== {2'b10, 16'hC001}) begin
                    bad++;
                    $display("FAIL %s_c_rvalid: got %h expected 2c001", tag,
                             {c_rvalid, l_rvalid, c_rdata});
                end
            end else if (pend == 1) begin
                total++;
                if ({c_rvalid, l_rvalid, l_rdata} !== {2'b01, 16'hA002}) begin
                    bad++;
                    $display("FAIL %s_l_rvalid: got %h expected 1a002", tag,
                             {c_rvalid, l_rvalid, l_rdata});
                end
            end
            pend = -1;
            if (ngr < n && (c_gnt || l_gnt)) begin
                order[ngr] = l_gnt;
                pend = l_gnt ? 1 : 0;
                ngr++;
            end
        end
        total++;
        if (ngr != n) begin bad++; $display("FAIL %s_count: got %0d expected %0d", tag, ngr, n); end
        total++;
        if (order !== exp_order) begin
            bad++;
            $display("FAIL %s_order: got %b expected %b (bit i = 1 for loader)", tag, order,
                     exp_order);
        end
        reset = 1'b1;
        c_req = 1'b0; l_req = 1'b0; c_lock = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_contention();
        run_tie(4, 8'b0000_1010, "rr");
    endtask

    task automatic test_reset_mid_read();
        bit got = 1'b0;
        l_req = 1'b1; l_we = 1'b0; l_addr = 5'd3;
        @(negedge clk);
        total++;
        if (l_gnt !== 1'b1) begin bad++; $display("FAIL mid_gnt: got %b expected 1", l_gnt); end
        l_req = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        total++;
        if ({l_rvalid, busy, l_rdata, mem_addr, mem_we} !== 24'h0) begin
            bad++;
            $display("FAIL mid_async: got %h expected 0", {l_rvalid, busy, l_rdata, mem_addr, mem_we});
        end
        @(negedge clk);
        total++;
        if (l_rvalid !== 1'b0) begin bad++; $display("FAIL mid_no_rvalid: got %b expected 0", l_rvalid); end
        c_req = 1'b1; c_we = 1'b0; c_addr = 5'd1;
        l_req = 1'b1; l_addr = 5'd2;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({c_gnt, l_gnt} !== 2'b10) begin
            bad++;
            $display("FAIL mid_tie_proc: got %b expected 10", {c_gnt, l_gnt});
        end
        c_req = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (l_gnt) got = 1'b1;
        end
        l_req = 1'b0;
        total++;
        if (!got) begin bad++; $display("FAIL mid_l_served: got 0 expected 1"); end
        repeat (2) @(negedge clk);
    endtask

`ifdef MEM_ARB_LOCK_EN
    task automatic test_lock();
        c_lock = 1'b1;
        run_tie(6, 8'b0010_0000, "lock");
    endtask
`endif

    task automatic test_idle_hold();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if ({mem_we, c_gnt, l_gnt, busy, mem_addr} !== 9'h0) begin
                bad++;
                $display("FAIL idle_%0d: got %h expected 0", i, {mem_we, c_gnt, l_gnt, busy, mem_addr});
            end
        end
    endtask

    initial begin
        reset = 1'b1; c_lock = 1'b0;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
        test_reset();
        test_single_read();
        test_write_readback();
        test_contention();
        test_reset_mid_read();
`ifdef MEM_ARB_LOCK_EN
        test_lock();
`endif
        test_idle_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
